// File: rtl/rr_grant_pkg.sv
// Shared state type and default sizing for the round-robin grant scheduler
// and its rotating-priority finder.
package rr_grant_pkg;

  localparam int STATE_W          = 2;
  localparam int DEFAULT_NUM_REQ  = 4;
  localparam int DEFAULT_MAX_HOLD = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant_pick.sv
// rr_pick: combinational rotating-priority finder; returns the first set request
// after i_last_ptr (wrapping), as both an index and a one-hot vector.
module rr_pick
  import rr_grant_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  logic [ID_W-1:0] w_cand;
  logic            w_hit;

  // Scan last_ptr+1 .. last_ptr+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand  = ID_W'((int'(i_last_ptr) + k) % NUM_REQ);
      w_hit   = ~o_found & i_req[w_cand];
      o_idx   = w_hit ? w_cand : o_idx;
      o_found = o_found | w_hit;
    end
    o_onehot = o_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin owner of one shared resource with req/done handshake.
// Define RR_GRANT_TIMEOUT_EN to revoke any grant held for MAX_HOLD cycles.
module rr_grant_scheduler
  import rr_grant_pkg::*;
#(
  parameter  int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter  int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_done,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [ID_W-1:0]    o_gnt_id,
  output logic               o_timeout
);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_gnt_valid, w_gnt_valid_nxt;
  logic [ID_W-1:0]    r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]    r_last_ptr, w_last_ptr_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_found;
  logic [ID_W-1:0]    w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic               w_release;
  logic               w_expire;

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
    $error("rr_grant_scheduler: NUM_REQ or MAX_HOLD out of range");
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req      (i_req),
    .i_last_ptr (r_last_ptr),
    .o_found    (w_found),
    .o_idx      (w_pick_idx),
    .o_onehot   (w_pick_onehot)
  );

  // A done strobe and a dropped request in the same cycle are one release.
  assign w_release = i_done[r_gnt_id] | ~i_req[r_gnt_id];

`ifdef RR_GRANT_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  // Grant-length counter: zero outside GRANT, counts each GRANT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_cnt <= 8'd0;
    end else if (r_state != GRANT) begin
      r_hold_cnt <= 8'd0;
    end else begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_expire = (r_hold_cnt == 8'(MAX_HOLD - 1)) & ~w_release;
`else
  assign w_expire = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_id_nxt    = r_gnt_id;
    w_last_ptr_nxt  = r_last_ptr;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = GRANT;
          w_gnt_nxt       = w_pick_onehot;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_id_nxt    = w_pick_idx;
        end else begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_id_nxt    = '0;
        end
      end
      GRANT: begin
        if (w_release | w_expire) begin
          w_state_nxt     = RELEASE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_id_nxt    = '0;
          w_last_ptr_nxt  = r_gnt_id;
          w_timeout_nxt   = w_expire;
        end else begin
          w_state_nxt     = GRANT;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        w_gnt_id_nxt    = '0;
      end
    endcase
  end

  // State and output registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last_ptr  <= ID_W'(NUM_REQ - 1);
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_last_ptr  <= w_last_ptr_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: a cycle reference model pushes expected
// outputs each edge; a negedge monitor pops and compares.
module tb_rr_grant_scheduler;

  localparam int NREQ = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam int MH    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic       to;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] done  = 4'b0000;
  logic [3:0] o_gnt;
  logic       o_gnt_valid;
  logic [1:0] o_gnt_id;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   dut_order[$];
  int   to_cnt = 0;

  always #5 clock = ~clock;

  rr_grant_scheduler #(.NUM_REQ(NREQ), .MAX_HOLD(MH)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_req       (req),
    .i_done      (done),
    .o_gnt       (o_gnt),
    .o_gnt_valid (o_gnt_valid),
    .o_gnt_id    (o_gnt_id),
    .o_timeout   (o_timeout)
  );

  function automatic bit has(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  // Reference model: owner index (-1 when free), cycles held, blind edges left after
  // a release, and the requester that most recently gave the resource back.
  int m_owner = -1;
  int m_held  = 0;
  int m_blind = 0;
  int m_last  = NREQ - 1;

  initial forever begin : model
    exp_t e;
    @(posedge clock or posedge reset);
    if (reset) begin
      m_owner = -1; m_held = 0; m_blind = 0; m_last = NREQ - 1;
      exp_q.delete();
    end else begin
      e = '0;
      if (m_owner >= 0) begin
        bit gave_up, expired;
        m_held++;
        gave_up = has(done, m_owner) || !has(req, m_owner);
        expired = TO_EN && (m_held >= MH) && !gave_up;
        if (gave_up || expired) begin
          m_last  = m_owner;
          m_owner = -1;
          m_blind = 1;
          e.to    = expired;
        end
      end else if (m_blind > 0) begin
        m_blind--;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (m_owner < 0 && has(req, c)) begin
            m_owner = c;
            m_held  = 0;
          end
        end
      end
      if (m_owner >= 0) begin
        e.gnt   = 4'b0001 << m_owner;
        e.valid = 1'b1;
        e.id    = 2'(m_owner);
      end
      exp_q.push_back(e);
    end
  end

  initial forever begin : monitor
    exp_t e, got;
    bit   prev_valid;
    @(negedge clock);
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      got = {o_gnt, o_gnt_valid, o_gnt_id, o_timeout};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t got=%b no expected entry", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_cycle t=%0t gnt/valid/id/to got=%b_%b_%0d_%b exp=%b_%b_%0d_%b",
                   $time, got.gnt, got.valid, got.id, got.to, e.gnt, e.valid, e.id, e.to);
        end
      end
      if (o_gnt_valid && !prev_valid) dut_order.push_back(int'(o_gnt_id));
      if (o_timeout) to_cnt++;
      prev_valid = o_gnt_valid;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, want);
    end
  endtask

  task automatic wait_grant(input logic [3:0] m, input int budget, input string nm);
    int n;
    n = 0;
    while (o_gnt !== m && n < budget) begin
      step();
      n++;
    end
    check(nm, {4'b0000, o_gnt}, {4'b0000, m});
  endtask

  initial begin : stim
    int base, held, tries, to_base;
    int rot_exp[5] = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {o_gnt, o_gnt_valid, o_gnt_id, o_timeout}, 8'h00);
    #2 reset = 1'b0;

    // Rotation: everyone requests, each owner releases after two cycles.
    base = dut_order.size();
    req  = 4'b1111;
    held = 0;
    tries = 0;
    while (dut_order.size() < base + 5 && tries < 80) begin
      done = 4'b0000;
      if (o_gnt_valid) begin
        held++;
        if (held == 2) begin
          done = o_gnt;
          held = 0;
        end
      end else begin
        held = 0;
      end
      step();
      tries++;
    end
    req = 4'b0000; done = 4'b0000;
    check("rotation_count", 8'(dut_order.size() - base), 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < dut_order.size()) check("rotation_order", 8'(dut_order[base + i]), 8'(rot_exp[i]));
    end
    repeat (3) step();

    // Single request with done from the owner.
    req = 4'b0100;
    wait_grant(4'b0100, 10, "single_grant");
    check("single_id", {6'd0, o_gnt_id}, 8'd2);
    step(); step();
    done = 4'b0100; req = 4'b0000;
    step();
    done = 4'b0000;
    check("single_released", {4'b0000, o_gnt}, 8'h00);
    repeat (3) step();

    // Non-owner done and req changes must not disturb owner 1.
    req = 4'b0010;
    wait_grant(4'b0010, 10, "noise_grant");
    req = 4'b0110; done = 4'b1001;
    step();
    req = 4'b0010; done = 4'b0000;
    step();
    check("noise_hold", {4'b0000, o_gnt}, 8'h02);
    done = 4'b0010; req = 4'b0000;
    step();
    done = 4'b0000;
    repeat (3) step();

    // Abandon by owner 3, then wrap to requester 0.
    req = 4'b1000;
    wait_grant(4'b1000, 10, "abandon_grant");
    step();
    req = 4'b0000;
    step();
    check("abandon_released", {4'b0000, o_gnt}, 8'h00);
    req = 4'b0001;
    wait_grant(4'b0001, 10, "wrap_grant");
    done = 4'b0001; req = 4'b0000;
    step();
    done = 4'b0000;
    repeat (3) step();

    // Randomized requester behaviour.
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] r, d;
      r = req;
      d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (o_gnt[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            d[i] = 1'b1;
            if ($urandom_range(0, 1) == 1) r[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            r[i] = 1'b0;
          end
        end else begin
          if (!r[i] && $urandom_range(0, 2) == 0) r[i] = 1'b1;
          if ($urandom_range(0, 7) == 0) d[i] = 1'b1;
        end
      end
      req = r; done = d;
      step();
    end
    req = 4'b0000; done = 4'b0000;
    repeat (5) step();

    // Asynchronous reset in the middle of a grant.
    req = 4'b0001;
    wait_grant(4'b0001, 20, "pre_reset_grant");
    #1 reset = 1'b1;
    #1 check("async_reset_drop", {3'b000, o_gnt, o_gnt_valid}, 8'h00);
    @(negedge clock);
    #2 reset = 1'b0;
    wait_grant(4'b0001, 10, "post_reset_grant");

    // Owner never signals done while another requester waits.
    to_base = to_cnt;
    req = 4'b0011;
    repeat (100) step();
`ifdef RR_GRANT_TIMEOUT_EN
    check("timeout_seen", 8'(to_cnt - to_base > 0), 8'd1);
`else
    check("hold_no_timeout", 8'(to_cnt - to_base), 8'd0);
    check("hold_owner", {4'b0000, o_gnt}, 8'h01);
`endif
    req = 4'b0000;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource among NUM_REQ requesters, following the grant style of the two-requester fixed-priority arbiter.
- Request/grant/done handshake, with one registered one-hot grant.
- Rotating priority gives starvation-free service.
- Sits between requester FSMs and the shared resource mux; gnt_id drives the mux select.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of gnt_id (derived; do not override).
- MAX_HOLD, 16, maximum grant length in cycles before forced revocation (used only with the optional feature; 1..255).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  level request, one bit per requester; held until granted.
- done  in  NUM_REQ  one-cycle release strobe from the owner.
- gnt  out  NUM_REQ  registered one-hot grant, or all zero.
- gnt_valid  out  1  OR of gnt, registered.
- gnt_id  out  ID_W  index of the current owner; 0 when gnt_valid=0.
- timeout  out  1  one-cycle pulse on forced revocation; tied 0 without the optional feature.

Behaviour:
- Reset (async, immediate): gnt=0, gnt_valid=0, gnt_id=0, timeout=0, state=IDLE, last_ptr=NUM_REQ-1 (so requester 0 has top priority first), hold_cnt=0.
- Reset asserted mid-grant drops gnt in the same cycle, without waiting for a clock.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0, select the first set bit scanning last_ptr+1, last_ptr+2, … modulo NUM_REQ.
  - Next edge: gnt, gnt_id and gnt_valid are set, state goes to GRANT.
  - Latency: req sampled high at edge t gives gnt high after edge t+1 (one cycle).
  - If req==0, stay in IDLE with all outputs 0.
- GRANT:
  - Owner is gnt_id. Exit when done[gnt_id]=1, or req[gnt_id]=0 (abandon).
  - On exit: next edge clears gnt and gnt_valid, sets last_ptr=gnt_id, state goes to RELEASE.
  - done from non-owners is ignored.
  - req changes on other bits do not preempt.
- RELEASE:
  - Exactly one dead cycle with gnt=0 for resource turnaround.
  - Next edge goes to IDLE.
  - Minimum per-grant occupancy: grant cycles + RELEASE + IDLE = N+2 cycles.
- done and req-drop in the same cycle are a single release; no double effect.
- Lone requester: re-granted after RELEASE and IDLE; no fairness penalty.
- Wrap-around: last_ptr=NUM_REQ-1 makes the scan start at index 0.
- The pointer updates only on release, never on an idle scan.
- gnt is one-hot by construction; gnt_id and gnt are always consistent.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- With the macro:
  - 8-bit hold_cnt clears on entry to GRANT and increments each GRANT cycle.
  - hold_cnt==MAX_HOLD-1 with no done forces the GRANT→RELEASE transition.
  - timeout pulses 1 on the same edge that clears gnt; last_ptr=gnt_id.
  - done arriving on the final cycle takes precedence (release, timeout=0).
- Without the macro: no counter, timeout constant 0, grants are unbounded.

Decomposition:
- Package rr_grant_pkg: state enum (IDLE, GRANT, RELEASE), state width constant, default NUM_REQ/MAX_HOLD constants.
- Sub-module rr_pick: combinational rotating-priority finder.
  - Inputs: req and last_ptr.
  - Outputs: found, idx, onehot.
  - Implemented as a double-width request vector with a mask, or a rotate + priority encoder.
  - Reused by the DMA scheduler.

Test Plan:
- Reset during GRANT: req=0001, granted, assert reset asynchronously mid-cycle → gnt=0000 before the next edge; after release, req=0001 is granted again with last_ptr=3 semantics.
- Single request:
  - req=0100 at edge 1 → gnt=0100, gnt_id=2 after edge 2.
  - done[2] at edge 5 → gnt=0 after edge 6.
  - Back in IDLE after edge 7.
- Rotation: req=1111 held, each owner pulses done after 2 cycles → grant order 0,1,2,3,0; no index repeats before all are served.
- Non-owner noise: owner 1, pulse done[0] and done[3], drop req[2] → gnt stays 0010.
- Abandon: owner 3 drops req[3] without done → release; next req=0001 is granted to 0 (wrap from pointer 3).
- Timeout (RR_GRANT_TIMEOUT_EN, MAX_HOLD=4): owner 0 never asserts done → gnt cleared after 4 grant cycles, timeout=1 for one cycle, next grant goes to 1 if req[1]=1. Without the macro the same stimulus holds the grant for 100 cycles with timeout=0.
